collision_detector: RTL
=======================

COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 Parameter COOLDOWN_FRAMES, default 4 (from package defines): number of whole frames obstacle detection stays disabled after an obstacle hit.
REQ-002 clk  input  1  system clock; all logic on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 startOfFrame  input  1  single-cycle pulse at the first pixel of each VGA frame.
REQ-005 pause  input  1  when high, the game is frozen and no collision is reported.
REQ-006 drawingRequestSmiley  input  1  smiley covers the current pixel.
REQ-007 drawingRequestBorderBottom  input  1  bottom border covers the current pixel.
REQ-008 drawingRequestBorderSide  input  1  left, right or top border covers the current pixel.
REQ-009 drawingRequestObstacle  input  1  an obstacle covers the current pixel.
REQ-010 obstacleIsGood  input  1  attribute of the obstacle at the current pixel: 1 good, 0 bad; valid only with drawingRequestObstacle.
REQ-011 collisionSmileyBorderBottom  output  1  single-cycle hit pulse.
REQ-012 collisionSmileyBorderSide  output  1  single-cycle hit pulse.
REQ-013 collisionSmileyObstacle  output  1  single-cycle hit pulse.
REQ-014 collisionSmileyObstacleGood / collisionSmileyObstacleBad  output  1 each  classification; asserted only in the same cycle as collisionSmileyObstacle, never both.

Function
REQ-015 An overlap is drawingRequestSmiley AND the channel's request, sampled in the same cycle.
REQ-016 The first overlap of a channel in a frame SHALL produce that channel's pulse exactly one cycle later, registered.
REQ-017 Further overlaps of the same channel in the same frame SHALL produce no pulse.
REQ-018 A startOfFrame pulse SHALL re-arm the bottom and side channels.
REQ-019 An overlap in the same cycle as startOfFrame SHALL count toward the new frame.
REQ-020 Channels are independent; simultaneous overlaps on several channels SHALL produce simultaneous pulses.
REQ-021 Good/Bad SHALL reflect obstacleIsGood at the overlap cycle that triggered the pulse.
REQ-022 While pause=1, overlaps SHALL be ignored and no pulse SHALL be emitted.
REQ-023 While pause=1, the per-frame armed state SHALL be held unchanged.
REQ-024 The obstacle channel FSM SHALL have the states ARMED, FIRED and COOLDOWN.
REQ-025 Obstacle FSM in ARMED: an overlap emits the pulse and moves the FSM to FIRED.
REQ-026 Obstacle FSM in FIRED: startOfFrame loads the cooldown counter with COOLDOWN_FRAMES and moves the FSM to COOLDOWN.
REQ-027 Obstacle FSM in COOLDOWN: each startOfFrame decrements the counter; when it reaches 0 the FSM returns to ARMED at that frame start.
REQ-028 Overlaps on the obstacle channel in FIRED or COOLDOWN SHALL be ignored.
REQ-029 The cooldown counter SHALL be $clog2(COOLDOWN_FRAMES+1) bits wide and SHALL saturate at 0, never wrapping.
REQ-030 COOLDOWN_FRAMES=0 SHALL behave as an obstacle channel that re-arms every frame.

Reset
REQ-031 reset=1 at a clock edge SHALL clear all outputs to 0.
REQ-032 reset SHALL return all channels to ARMED and clear the cooldown counter to 0, including mid-frame and mid-cooldown.
REQ-033 A pulse that is pending in the cycle reset is asserted SHALL be dropped.

Configuration
REQ-034 Macro COLLISION_COOLDOWN_EN defined: the obstacle FSM uses COOLDOWN as specified in REQ-024 to REQ-030.
REQ-035 Macro COLLISION_COOLDOWN_EN undefined: no COOLDOWN state and no counter; FIRED returns to ARMED on the next startOfFrame, and COOLDOWN_FRAMES is ignored.

Structure
REQ-036 Package defines SHALL hold COOLDOWN_FRAMES and the typedef enum for the obstacle FSM states.
REQ-037 Sub-module collision_oneshot (overlap, re-arm and pause in; registered single-cycle pulse out) SHALL be instantiated once per channel.
REQ-038 The obstacle FSM and cooldown counter SHALL live in collision_detector, which drives the obstacle collision_oneshot's re-arm input.

Verification
REQ-039 Smiley and BorderBottom overlap for 10 consecutive cycles in frame 1 -> exactly one BorderBottom pulse, one cycle after the first overlap; a repeat in frame 2 gives one more pulse.
REQ-040 Obstacle overlap with obstacleIsGood=1 in frame 1, then overlaps in frames 2-5, then in frame 6 (COOLDOWN_FRAMES=4, macro defined) -> Obstacle+Good pulse in frame 1, none in frames 2-5, Obstacle pulse in frame 6.
REQ-041 Same stimulus as REQ-040 with the macro undefined -> one Obstacle pulse in every frame, 1 through 6.
REQ-042 Bottom, side and obstacle overlap in the same cycle with obstacleIsGood=0 -> BorderBottom, BorderSide, Obstacle and Bad all pulse in the same cycle; Good stays 0.
REQ-043 pause=1 for a whole frame containing overlaps -> no pulses; after pause drops to 0 in the same frame, the next overlap pulses.
REQ-044 reset asserted during cooldown (counter=2) -> all outputs 0 next cycle; the first obstacle overlap after reset pulses immediately.

Source files
------------

// File: rtl/collision_detector_pkg.sv
// Shared constants and obstacle FSM state type for the collision detector.
// COLLISION_COOLDOWN_EN selects whether the COOLDOWN state exists.
package collision_detector_pkg;

  localparam int COOLDOWN_FRAMES = 4;

`ifdef COLLISION_COOLDOWN_EN
  typedef enum logic [1:0] {ARMED, FIRED, COOLDOWN} obs_state_t;
`else
  typedef enum logic [0:0] {ARMED, FIRED} obs_state_t;
`endif

  // A zero-frame cooldown still needs a 1-bit counter to keep declarations legal.
  function automatic int cnt_width(input int frames);
    return (frames > 0) ? $clog2(frames + 1) : 1;
  endfunction

endpackage

// File: rtl/collision_oneshot.sv
// One collision channel: reports the first overlap after arming as a
// registered single-cycle pulse; pause freezes the armed state.
module collision_oneshot (
  input  logic clk,
  input  logic reset,
  input  logic overlap,
  input  logic rearm,
  input  logic pause,
  output logic pulse
);

  logic armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= 1'b1;
      pulse <= 1'b0;
    end else if (pause) begin
      pulse <= 1'b0;
    end else begin
      // an overlap coinciding with re-arm belongs to the new frame
      pulse <= overlap & (armed | rearm);
      if (overlap)
        armed <= 1'b0;
      else if (rearm)
        armed <= 1'b1;
    end
  end

endmodule

// File: rtl/collision_detector.sv
// Smiley collision detector: per-frame one-shots for borders and an obstacle
// channel gated by an FSM, with optional cooldown under COLLISION_COOLDOWN_EN.
module collision_detector #(
  parameter int COOLDOWN_FRAMES = collision_detector_pkg::COOLDOWN_FRAMES
) (
  input  logic clk,
  input  logic reset,
  input  logic startOfFrame,
  input  logic pause,
  input  logic drawingRequestSmiley,
  input  logic drawingRequestBorderBottom,
  input  logic drawingRequestBorderSide,
  input  logic drawingRequestObstacle,
  input  logic obstacleIsGood,
  output logic collisionSmileyBorderBottom,
  output logic collisionSmileyBorderSide,
  output logic collisionSmileyObstacle,
  output logic collisionSmileyObstacleGood,
  output logic collisionSmileyObstacleBad
);

  import collision_detector_pkg::*;

  logic ov_bottom, ov_side, ov_obs;
  logic rearm_obs;
  logic good_q;
  obs_state_t state;

  assign ov_bottom = drawingRequestSmiley & drawingRequestBorderBottom;
  assign ov_side   = drawingRequestSmiley & drawingRequestBorderSide;
  assign ov_obs    = drawingRequestSmiley & drawingRequestObstacle;

`ifdef COLLISION_COOLDOWN_EN
  localparam int CW = cnt_width(COOLDOWN_FRAMES);
  logic [CW-1:0] cnt;

  always_comb begin
    rearm_obs = 1'b0;
    if (startOfFrame) begin
      case (state)
        FIRED:    rearm_obs = (COOLDOWN_FRAMES == 0);
        COOLDOWN: rearm_obs = (cnt <= CW'(1));
        default:  rearm_obs = 1'b0;
      endcase
    end
  end
`else
  logic unused_cooldown_cfg;
  assign unused_cooldown_cfg = (COOLDOWN_FRAMES != 0);
  assign rearm_obs = startOfFrame & (state == FIRED);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ARMED;
      good_q <= 1'b0;
`ifdef COLLISION_COOLDOWN_EN
      cnt    <= '0;
`endif
    end else if (!pause) begin
      good_q <= obstacleIsGood;
      case (state)
        ARMED: if (ov_obs) state <= FIRED;
`ifdef COLLISION_COOLDOWN_EN
        FIRED: begin
          if (rearm_obs)
            state <= ov_obs ? FIRED : ARMED;
          else if (startOfFrame) begin
            state <= COOLDOWN;
            cnt   <= CW'(COOLDOWN_FRAMES);
          end
        end
        COOLDOWN: begin
          if (rearm_obs) begin
            cnt   <= '0;
            state <= ov_obs ? FIRED : ARMED;
          end else if (startOfFrame)
            cnt <= cnt - CW'(1);
        end
`else
        FIRED: if (rearm_obs) state <= ov_obs ? FIRED : ARMED;
`endif
        default: state <= ARMED;
      endcase
    end
  end

  collision_oneshot u_bottom (
    .clk(clk), .reset(reset), .overlap(ov_bottom), .rearm(startOfFrame),
    .pause(pause), .pulse(collisionSmileyBorderBottom)
  );

  collision_oneshot u_side (
    .clk(clk), .reset(reset), .overlap(ov_side), .rearm(startOfFrame),
    .pause(pause), .pulse(collisionSmileyBorderSide)
  );

  collision_oneshot u_obstacle (
    .clk(clk), .reset(reset), .overlap(ov_obs), .rearm(rearm_obs),
    .pause(pause), .pulse(collisionSmileyObstacle)
  );

  // good_q holds the attribute from the overlap cycle, aligned with the pulse
  assign collisionSmileyObstacleGood = collisionSmileyObstacle & good_q;
  assign collisionSmileyObstacleBad  = collisionSmileyObstacle & ~good_q;

endmodule
